// File: rtl/serial_add3.sv
// Bit-serial adder: one shared full-adder cell with a registered carry walks
// the operands LSB first and returns {co, s} = a + b + ci over valid/ready.
module serial_add3 #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, msb;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, co_q, co_d, sum_bit;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    co_d    = co_q;
    sum_bit = a_q[0] ^ b_q[0] ^ carry_q;
    msb     = '0;
    msb[WIDTH-1] = sum_bit;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        // New bit enters at the MSB so bit 0 lands in s[0] after WIDTH shifts.
        s_d     = (s_q >> 1) | msb;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          co_d    = carry_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      co_q    <= co_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign co        = co_q;

endmodule

// File: tb/tb_serial_add3.sv
// Scoreboard bench for serial_add3: driver pushes a+b+ci on accept, an
// independent monitor pops and compares on every result handshake.
module tb_serial_add3;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, ci, co;
  logic [W-1:0] a, b, s;

  serial_add3 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W:0] exp_q[$];
  int  checks = 0, errors = 0;
  bit  rand_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: a result handshake happens on the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h, expected none", {co, s});
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("result", 32'({co, s}), 32'(e));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tci,
                      output int acc_cyc);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    a = ta; b = tb_; ci = tci; in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    acc_cyc = cyc;
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no in_ready, expected acceptance");
    end else begin
      exp_q.push_back({1'b0, ta} + {1'b0, tb_} + (W+1)'(tci));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble operands after acceptance; the result must not follow them.
    a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) return;
    end
    checks++; errors++;
    $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
  endtask

  initial begin
    int t1, t2, lat, seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ci = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_s", 32'(s), 0);
    chk("rst_co", 32'(co), 0);
    @(negedge clk); rst = 1'b0;

    // 3+5+0, latency and in_ready low while busy
    out_ready = 1'b1;
    send(3'd3, 3'd5, 1'b0, t1);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
      chk("busy_in_ready", 32'(in_ready), 0);
      lat++;
    end
    chk("latency", 32'(lat), 3);
    chk("s_3_5", 32'(s), 0);
    chk("co_3_5", 32'(co), 1);
    wait_drain();

    // Back-to-back issue interval
    send(3'd7, 3'd7, 1'b1, t1);
    send(3'd0, 3'd0, 1'b0, t2);
    chk("issue_interval", 32'(t2 - t1), 5);
    wait_drain();

    // Backpressure with input noise
    out_ready = 1'b0;
    send(3'd4, 3'd2, 1'b0, t1);
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid; a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_result", 32'({co, s}), 32'(6));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("consume_valid", 32'(out_valid), 0);
    chk("consume_in_ready", 32'(in_ready), 1);
    wait_drain();

    // Asynchronous reset during the second ADD cycle
    send(3'd5, 3'd6, 1'b1, t1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_s", 32'(s), 0);
    chk("arst_co", 32'(co), 0);
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no_valid_after_abort", 32'(seen), 0);
    send(3'd2, 3'd1, 1'b1, t1);
    wait_drain();
    chk("post_reset_result", 32'({co, s}), 32'(4));

    // Operand change right after accept
    send(3'd1, 3'd2, 1'b0, t1);
    a = 3'd6;
    wait_drain();
    chk("operand_hold", 32'({co, s}), 32'(3));

    // Exhaustive sweep under random stalls, then random traffic
    rand_ready = 1'b1;
    for (int i = 0; i < 128; i++) begin
      logic [6:0] v;
      v = 7'(i);
      send(v[2:0], v[5:3], v[6], t1);
    end
    for (int i = 0; i < 40; i++) send(W'($urandom), W'($urandom), 1'($urandom), t1);
    wait_drain();
    rand_ready = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
